// File: rtl/program_loader_pkg.sv
// Shared defaults, HALT opcode and FSM state encodings for the boot-time program loader.
package program_loader_pkg;

    localparam int LEN_ADDR  = 7;
    localparam int LEN_DATA  = 32;
    localparam int RAM_DEPTH = 128;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECV   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_DONE   = 3'd4,
        ST_CKSUM  = 3'd5
    } state_t;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Packs bytes MSB-first into a len_data word; word/word_valid present the completed word in the
// same cycle as its last byte so the loader can latch it without an extra stage.
module byte_packer #(
    parameter int len_data = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                byte_valid,
    input  logic [7:0]          byte_in,
    output logic                word_valid,
    output logic [len_data-1:0] word
);

    localparam int NUM_BYTES = len_data / 8;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    logic [len_data-9:0] shift_reg;
    logic [CNT_W-1:0]    count_reg;

    // Lane 0 is the incoming byte; older bytes sit above it in the shift register.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            if (gi == 0) begin : g_new
                assign word[7:0] = byte_in;
            end else begin : g_old
                assign word[gi*8 +: 8] = shift_reg[(gi-1)*8 +: 8];
            end
        end
    endgenerate

    assign word_valid = byte_valid && (count_reg == LAST_BYTE);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift_reg <= '0;
            count_reg <= '0;
        end else if (byte_valid) begin
            shift_reg <= word[len_data-9:0];
            count_reg <= word_valid ? '0 : count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: packs UART bytes into words and writes them to instruction memory until HALT or full.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check (state CKSUM, port cksum_err).
module program_loader
    import program_loader_pkg::*;
#(
    parameter int len_addr  = LEN_ADDR,
    parameter int len_data  = LEN_DATA,
    parameter int ram_depth = RAM_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_req,
    input  logic                rx_done,
    input  logic [7:0]          rx_data,
    output logic                mem_wr,
    output logic [len_addr-1:0] mem_addr,
    output logic [len_data-1:0] mem_data,
    output logic [len_addr:0]   prog_len,
    output logic                load_busy,
    output logic                load_done,
    output logic                overflow,
`ifdef LOADER_CHECKSUM_EN
    output logic                cksum_err,
`endif
    output logic                cpu_run
);

    localparam int PL_W = len_addr + 1;
    localparam logic [len_addr-1:0] LAST_ADDR = len_addr'(ram_depth - 1);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t HALT_NEXT = ST_CKSUM;
`else
    localparam state_t HALT_NEXT = ST_DONE;
`endif

    state_t              state_reg, state_next;
    logic [len_addr-1:0] mem_addr_reg;
    logic [len_addr-1:0] wr_addr_reg;
    logic [len_data-1:0] mem_data_reg;
    logic [PL_W-1:0]     prog_len_reg;
    logic                overflow_reg;
    logic                pend_valid_reg;
    logic [7:0]          pend_byte_reg;

    logic                start;
    logic                src_valid;
    logic [7:0]          src_byte;
    logic                byte_take;
    logic                word_valid;
    logic [len_data-1:0] packed_word;
    logic                is_halt;
    logic                at_last;
    logic                cksum_bad;

    assign start     = load_req && (state_reg == ST_IDLE || state_reg == ST_DONE);
    // A pending byte is always older than a byte arriving this cycle, so it goes first.
    assign src_valid = pend_valid_reg || rx_done;
    assign src_byte  = pend_valid_reg ? pend_byte_reg : rx_data;
    assign byte_take = (state_reg == ST_RECV) && src_valid;
    assign is_halt   = (mem_data_reg[len_data-1 -: 6] == HALT_OPCODE);
    assign at_last   = (mem_addr_reg == LAST_ADDR);

    byte_packer #(
        .len_data (len_data)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start),
        .byte_valid (byte_take),
        .byte_in    (src_byte),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            mem_addr_reg   <= '0;
            wr_addr_reg    <= '0;
            mem_data_reg   <= '0;
            prog_len_reg   <= '0;
            overflow_reg   <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_byte_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                mem_addr_reg <= '0;
                wr_addr_reg  <= '0;
                prog_len_reg <= '0;
                overflow_reg <= 1'b0;
            end
            // Address is committed with the word so it stays put through SETUP, STROBE and after.
            if (word_valid) begin
                mem_data_reg <= packed_word;
                mem_addr_reg <= wr_addr_reg;
            end
            if (state_reg == ST_STROBE) begin
                prog_len_reg <= prog_len_reg + PL_W'(1);
                if (!is_halt) begin
                    if (at_last) begin
                        overflow_reg <= 1'b1;
                    end else begin
                        wr_addr_reg <= wr_addr_reg + len_addr'(1);
                    end
                end
            end
            case (state_reg)
                ST_RECV, ST_CKSUM: begin
                    if (pend_valid_reg) begin
                        pend_valid_reg <= rx_done && (state_reg == ST_RECV);
                        pend_byte_reg  <= rx_data;
                    end
                end
                ST_SETUP, ST_STROBE: begin
                    if (rx_done && !pend_valid_reg) begin
                        pend_valid_reg <= 1'b1;
                        pend_byte_reg  <= rx_data;
                    end
                end
                default: begin
                    if (start) begin
                        pend_valid_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] cksum_reg;
    logic       cksum_err_reg;

    always_ff @(posedge clk) begin
        if (reset || start) begin
            cksum_reg     <= '0;
            cksum_err_reg <= 1'b0;
        end else if (byte_take) begin
            cksum_reg <= cksum_reg ^ src_byte;
        end else if (state_reg == ST_CKSUM && src_valid) begin
            cksum_err_reg <= (src_byte != cksum_reg);
        end
    end

    assign cksum_err = cksum_err_reg;
    assign cksum_bad = cksum_err_reg;
`else
    assign cksum_bad = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        mem_wr     = 1'b0;
        load_busy  = 1'b0;
        load_done  = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                load_done = (state_reg == ST_DONE);
                if (load_req) state_next = ST_RECV;
            end
            ST_RECV: begin
                load_busy = 1'b1;
                if (word_valid) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                load_busy  = 1'b1;
                state_next = ST_STROBE;
            end
            ST_STROBE: begin
                load_busy = 1'b1;
                mem_wr    = 1'b1;
                if (is_halt)      state_next = HALT_NEXT;
                else if (at_last) state_next = ST_DONE;
                else              state_next = ST_RECV;
            end
            ST_CKSUM: begin
                if (src_valid) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign mem_addr = mem_addr_reg;
    assign mem_data = mem_data_reg;
    assign prog_len = prog_len_reg;
    assign overflow = overflow_reg;
    assign cpu_run  = load_done && !overflow_reg && !cksum_bad;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, packing/timing, pending byte, reset mid-word,
// overflow, and (with LOADER_CHECKSUM_EN) checksum accept/reject.
module tb_program_loader;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_req;
    logic          rx_done;
    logic [7:0]    rx_data;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [AW:0]   prog_len;
    logic          load_busy;
    logic          load_done;
    logic          overflow;
    logic          cpu_run;
`ifdef LOADER_CHECKSUM_EN
    logic          cksum_err;
`endif

    int checks = 0;
    int errors = 0;

    int            wr_count = 0;
    logic [AW-1:0] log_addr [0:511];
    logic [DW-1:0] log_data [0:511];
    int            base;

    always #5 clk = ~clk;

    program_loader dut (
        .clk       (clk),
        .reset     (reset),
        .load_req  (load_req),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .prog_len  (prog_len),
        .load_busy (load_busy),
        .load_done (load_done),
        .overflow  (overflow),
`ifdef LOADER_CHECKSUM_EN
        .cksum_err (cksum_err),
`endif
        .cpu_run   (cpu_run)
    );

    // Record every memory write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_wr) begin
            if (wr_count < 512) begin
                log_addr[wr_count] <= mem_addr;
                log_data[wr_count] <= mem_data;
            end
            wr_count <= wr_count + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_done = 1'b1;
        rx_data = b;
        tick(1);
        rx_done = 1'b0;
        if (gap > 0) tick(gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gap);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        tick(1);
    endtask

    task automatic send_cksum(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
        send_byte(c, 3);
`else
        rx_data = c;
        tick(1);
`endif
    endtask

    initial begin
        reset    = 1'b1;
        load_req = 1'b0;
        rx_done  = 1'b0;
        rx_data  = 8'h00;
        tick(3);
        chk("rst_mem_wr",    64'(mem_wr),    64'h0);
        chk("rst_mem_addr",  64'(mem_addr),  64'h0);
        chk("rst_mem_data",  64'(mem_data),  64'h0);
        chk("rst_prog_len",  64'(prog_len),  64'h0);
        chk("rst_load_busy", 64'(load_busy), 64'h0);
        chk("rst_load_done", 64'(load_done), 64'h0);
        chk("rst_overflow",  64'(overflow),  64'h0);
        chk("rst_cpu_run",   64'(cpu_run),   64'h0);
        reset = 1'b0;
        tick(1);
        $display("step: reset state checked");

        // Basic two-word program with latency check on the first word.
        pulse_load();
        chk("t1_busy", 64'(load_busy), 64'h1);
        base = wr_count;
        send_byte(8'h20, 2);
        send_byte(8'h08, 2);
        send_byte(8'h00, 2);
        rx_done = 1'b1;
        rx_data = 8'h05;
        tick(1);
        rx_done = 1'b0;
        chk("t1_n1_wr",   64'(mem_wr),   64'h0);
        chk("t1_n1_data", 64'(mem_data), 64'h20080005);
        chk("t1_n1_addr", 64'(mem_addr), 64'h0);
        tick(1);
        chk("t1_n2_wr",   64'(mem_wr),   64'h1);
        chk("t1_n2_data", 64'(mem_data), 64'h20080005);
        chk("t1_n2_addr", 64'(mem_addr), 64'h0);
        tick(1);
        chk("t1_n3_wr",   64'(mem_wr),   64'h0);
        chk("t1_n3_data", 64'(mem_data), 64'h20080005);
        chk("t1_n3_addr", 64'(mem_addr), 64'h0);
        tick(1);
        send_word(32'hFC000000, 2);
        tick(4);
        send_cksum(8'hD1);
        tick(2);
        chk("t1_wr_count", 64'(wr_count - base), 64'd2);
        chk("t1_w0_addr",  64'(log_addr[base]),   64'h0);
        chk("t1_w0_data",  64'(log_data[base]),   64'h20080005);
        chk("t1_w1_addr",  64'(log_addr[base+1]), 64'h1);
        chk("t1_w1_data",  64'(log_data[base+1]), 64'hFC000000);
        chk("t1_done",     64'(load_done), 64'h1);
        chk("t1_busy_end", 64'(load_busy), 64'h0);
        chk("t1_prog_len", 64'(prog_len),  64'd2);
        chk("t1_overflow", 64'(overflow),  64'h0);
        chk("t1_cpu_run",  64'(cpu_run),   64'h1);
        send_word(32'h12345678, 1);
        tick(3);
        chk("t1_done_ignore_cnt",  64'(wr_count - base), 64'd2);
        chk("t1_done_ignore_data", 64'(mem_data), 64'hFC000000);
        $display("step: basic load and timing checked");

        // Byte arriving during STROBE becomes the first byte of the next word.
        pulse_load();
        base = wr_count;
        send_byte(8'h01, 2);
        send_byte(8'h02, 2);
        send_byte(8'h03, 2);
        rx_done = 1'b1;
        rx_data = 8'h04;
        tick(1);
        rx_done = 1'b0;
        tick(1);
        chk("t2_in_strobe", 64'(mem_wr), 64'h1);
        rx_done = 1'b1;
        rx_data = 8'h11;
        tick(1);
        rx_done = 1'b0;
        tick(2);
        send_byte(8'h22, 2);
        send_byte(8'h33, 2);
        send_byte(8'h44, 2);
        tick(2);
        send_word(32'hFC000000, 2);
        tick(4);
        send_cksum(8'hBC);
        tick(2);
        chk("t2_wr_count", 64'(wr_count - base), 64'd3);
        chk("t2_w0_data",  64'(log_data[base]),   64'h01020304);
        chk("t2_w1_addr",  64'(log_addr[base+1]), 64'h1);
        chk("t2_w1_data",  64'(log_data[base+1]), 64'h11223344);
        chk("t2_w2_data",  64'(log_data[base+2]), 64'hFC000000);
        chk("t2_prog_len", 64'(prog_len), 64'd3);
        chk("t2_cpu_run",  64'(cpu_run),  64'h1);
        $display("step: pending byte checked");

        // Reset two bytes into a word, then reload; load_req mid-word must be ignored.
        pulse_load();
        send_byte(8'hAA, 2);
        send_byte(8'hBB, 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t3_rst_busy", 64'(load_busy), 64'h0);
        chk("t3_rst_len",  64'(prog_len),  64'h0);
        chk("t3_rst_addr", 64'(mem_addr),  64'h0);
        chk("t3_rst_data", 64'(mem_data),  64'h0);
        chk("t3_rst_done", 64'(load_done), 64'h0);
        base = wr_count;
        pulse_load();
        send_byte(8'h20, 2);
        send_byte(8'h08, 2);
        pulse_load();
        send_byte(8'h00, 2);
        send_byte(8'h05, 2);
        tick(2);
        send_word(32'hFC000000, 2);
        tick(4);
        send_cksum(8'hD1);
        tick(2);
        chk("t3_wr_count", 64'(wr_count - base), 64'd2);
        chk("t3_w0_addr",  64'(log_addr[base]),   64'h0);
        chk("t3_w0_data",  64'(log_data[base]),   64'h20080005);
        chk("t3_w1_data",  64'(log_data[base+1]), 64'hFC000000);
        chk("t3_cpu_run",  64'(cpu_run), 64'h1);
        $display("step: reset mid-word and reload checked");

        // Fill memory without HALT.
        pulse_load();
        base = wr_count;
        for (int i = 0; i < 128; i++) send_word(32'(i), 2);
        tick(4);
        chk("t4_wr_count",  64'(wr_count - base), 64'd128);
        chk("t4_w64_addr",  64'(log_addr[base+64]),  64'd64);
        chk("t4_w64_data",  64'(log_data[base+64]),  64'd64);
        chk("t4_w127_addr", 64'(log_addr[base+127]), 64'd127);
        chk("t4_w127_data", 64'(log_data[base+127]), 64'd127);
        chk("t4_overflow",  64'(overflow),  64'h1);
        chk("t4_done",      64'(load_done), 64'h1);
        chk("t4_cpu_run",   64'(cpu_run),   64'h0);
        chk("t4_prog_len",  64'(prog_len),  64'd128);
        send_word(32'h00000099, 2);
        tick(4);
        chk("t4_no_extra_wr", 64'(wr_count - base), 64'd128);
        chk("t4_addr_hold",   64'(mem_addr), 64'd127);
        pulse_load();
        chk("t4_reload_ovf", 64'(overflow), 64'h0);
        chk("t4_reload_len", 64'(prog_len), 64'h0);
        $display("step: overflow checked");

`ifdef LOADER_CHECKSUM_EN
        send_word(32'hFC000000, 2);
        tick(3);
        chk("t5_wait_cksum", 64'(load_done), 64'h0);
        send_byte(8'hFC, 3);
        chk("t5_ok_err",  64'(cksum_err), 64'h0);
        chk("t5_ok_done", 64'(load_done), 64'h1);
        chk("t5_ok_run",  64'(cpu_run),   64'h1);
        pulse_load();
        send_word(32'hFC000000, 2);
        tick(3);
        send_byte(8'h00, 3);
        chk("t5_bad_err",  64'(cksum_err), 64'h1);
        chk("t5_bad_done", 64'(load_done), 64'h1);
        chk("t5_bad_run",  64'(cpu_run),   64'h0);
        pulse_load();
        chk("t5_clear_err", 64'(cksum_err), 64'h0);
        $display("step: checksum checked");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
